// File: rtl/jesd204_soft_pcs_pkg.sv
// Shared soft-PCS receive definitions.
// Comma patterns, symbol width and aligner state encodings.
package jesd204_soft_pcs_pkg;

  localparam int SYM_W = 10;

  // 7-bit comma prefix, bit 0 = first bit on the wire ('a')
  localparam logic [6:0] COMMA_NEG = 7'b1111100;
  localparam logic [6:0] COMMA_POS = 7'b0000011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

endpackage

// File: rtl/jesd204_comma_detect.sv
// K28.5 comma search across all lane positions of a two-beat window.
// hit[k] flags a comma at bit offset k of any symbol slot.
module jesd204_comma_detect
  import jesd204_soft_pcs_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic [SYM_W*DATA_PATH_WIDTH+5:0] window,
  output logic [9:0]                       hit,
  output logic [3:0]                       first_k
);

  always_comb begin
    hit = '0;
    for (int k = 0; k < SYM_W; k++) begin
      for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
        if (window[SYM_W*j+k +: 7] == COMMA_NEG ||
            window[SYM_W*j+k +: 7] == COMMA_POS) begin
          hit[k] = 1'b1;
        end
      end
    end
  end

  // lowest offset wins when several slots match
  always_comb begin
    first_k = '0;
    for (int k = SYM_W - 1; k >= 0; k--) begin
      if (hit[k]) begin
        first_k = 4'(k);
      end
    end
  end

endmodule

// File: rtl/jesd204_soft_pcs_rx_comma_align.sv
// Receive word aligner: finds K28.5, locks a bit offset after
// repeated confirmation and emits symbol-aligned beats.
module jesd204_soft_pcs_rx_comma_align
  import jesd204_soft_pcs_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int LOCK_COUNT      = 4,
  parameter int UNLOCK_COUNT    = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             patternalign_en,
  input  logic [SYM_W*DATA_PATH_WIDTH-1:0] in_data,
  output logic [SYM_W*DATA_PATH_WIDTH-1:0] out_data,
  output logic                             out_locked,
  output logic [3:0]                       out_offset,
  output logic                             out_lock_lost
);

  localparam int W = SYM_W * DATA_PATH_WIDTH;
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  align_state_t   state_q, state_d;
  logic [3:0]     offset_q, offset_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     miss_q, miss_d;
  logic           locked_d;
  logic           lost_d;
  logic [W-1:0]   prev_q;
  logic [2*W-1:0] window;
  logic [9:0]     hit;
  logic [3:0]     first_k;
  logic           any_hit;
  logic           cur_hit;
  logic [3:0]     cnt_inc;
  logic [3:0]     miss_inc;

  assign window = {in_data, prev_q};

  jesd204_comma_detect #(
    .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
  ) u_detect (
    .window  (window[W+5:0]),
    .hit     (hit),
    .first_k (first_k)
  );

  assign any_hit  = |hit;
  assign cur_hit  = hit[offset_q];
  assign cnt_inc  = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
  assign miss_inc = (miss_q == 4'hf) ? miss_q : miss_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    locked_d = out_locked;
    lost_d   = 1'b0;
    if (patternalign_en) begin
      unique case (state_q)
        SEARCH: begin
          if (any_hit) begin
            offset_d = first_k;
            cnt_d    = 4'd1;
            if (LOCK_N == 4'd1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (cur_hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else if (any_hit) begin
            offset_d = first_k;
            cnt_d    = 4'd1;
          end
        end
        LOCKED: begin
          // data beats without any comma leave the miss count alone
          if (cur_hit) begin
            miss_d = '0;
          end else if (any_hit) begin
            miss_d = miss_inc;
            if (miss_inc == UNLOCK_N) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              lost_d   = 1'b1;
              cnt_d    = '0;
            end
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= SEARCH;
      offset_q      <= '0;
      cnt_q         <= '0;
      miss_q        <= '0;
      prev_q        <= '0;
      out_data      <= '0;
      out_locked    <= 1'b0;
      out_lock_lost <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      cnt_q         <= cnt_d;
      miss_q        <= miss_d;
      prev_q        <= in_data;
      out_data      <= window[offset_q +: W];
      out_locked    <= locked_d;
      out_lock_lost <= lost_d;
    end
  end

  assign out_offset = offset_q;

endmodule

// File: tb/tb_jesd204_soft_pcs_rx_comma_align.sv
// Scoreboard bench for the receive comma aligner.
// Directed beat streams with hand-derived per-cycle expectations.
module tb_jesd204_soft_pcs_rx_comma_align;

  localparam int W = 40;

  localparam logic [9:0] K285 = 10'b0101111100;
  localparam logic [9:0] D215 = 10'b0101010101;
  localparam logic [W-1:0] B    = {D215, D215, D215, K285};
  localparam logic [W-1:0] IDLE = {D215, D215, D215, D215};

  typedef struct {
    int           id;
    logic         cd;
    logic [W-1:0] d;
    logic         lk;
    logic [3:0]   off;
    logic         lost;
  } exp_t;

  logic         clk;
  logic         resetn;
  logic         patternalign_en;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  logic         out_locked;
  logic [3:0]   out_offset;
  logic         out_lock_lost;

  exp_t q[$];
  int   checks;
  int   failures;
  int   beat_id;

  logic [W-1:0] r3;
  logic [W-1:0] r7;

  jesd204_soft_pcs_rx_comma_align #(
    .DATA_PATH_WIDTH (4),
    .LOCK_COUNT      (4),
    .UNLOCK_COUNT    (8)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .patternalign_en (patternalign_en),
    .in_data         (in_data),
    .out_data        (out_data),
    .out_locked      (out_locked),
    .out_offset      (out_offset),
    .out_lock_lost   (out_lock_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int s);
    logic [W-1:0] r;
    if (s == 0) r = v;
    else r = (v << s) | (v >> (W - s));
    return r;
  endfunction

  task automatic cmp(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] d, input logic e,
                      input logic xl, input logic [3:0] xo,
                      input logic xlost, input logic cd,
                      input logic [W-1:0] xd);
    exp_t x;
    @(negedge clk);
    resetn          = r;
    in_data         = d;
    patternalign_en = e;
    beat_id++;
    x.id   = beat_id;
    x.cd   = cd;
    x.d    = xd;
    x.lk   = xl;
    x.off  = xo;
    x.lost = xlost;
    q.push_back(x);
    if (!r) begin
      #1;
      cmp($sformatf("async_rst%0d_data", beat_id), out_data, '0);
      cmp($sformatf("async_rst%0d_locked", beat_id), 40'(out_locked), '0);
      cmp($sformatf("async_rst%0d_offset", beat_id), 40'(out_offset), '0);
      cmp($sformatf("async_rst%0d_lost", beat_id), 40'(out_lock_lost), '0);
    end
  endtask

  // monitor: one output beat per clock, checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp($sformatf("b%0d_locked", e.id), 40'(out_locked), 40'(e.lk));
        cmp($sformatf("b%0d_offset", e.id), 40'(out_offset), 40'(e.off));
        cmp($sformatf("b%0d_lost", e.id), 40'(out_lock_lost), 40'(e.lost));
        if (e.cd) cmp($sformatf("b%0d_data", e.id), out_data, e.d);
      end
    end
  end

  initial begin
    int guard;
    checks          = 0;
    failures        = 0;
    beat_id         = 0;
    resetn          = 1'b0;
    patternalign_en = 1'b0;
    in_data         = '0;
    r3 = rotl(B, 3);
    r7 = rotl(B, 7);

    // offset 0: first hit needs the comma in prev, lock on 4th hit
    for (int i = 0; i < 2; i++) step(1'b0, B, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 8; i++)
      step(1'b1, B, 1'b1, i >= 5, 4'd0, 1'b0, 1'b1, (i == 1) ? '0 : B);

    // stream shifted by 3
    for (int i = 0; i < 2; i++) step(1'b0, r3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 8; i++)
      step(1'b1, r3, 1'b1, i >= 5, (i >= 2) ? 4'd3 : 4'd0, 1'b0, i >= 3, B);

    // re-shift to 7: 8 misaligned beats drop lock, relock at 7
    for (int t = 1; t <= 14; t++)
      step(1'b1, r7, 1'b1, (t <= 8) || (t >= 13), (t <= 9) ? 4'd3 : 4'd7,
           t == 9, t >= 11, B);

    // long data phase, one stray comma, then aligned again
    for (int i = 0; i < 100; i++)
      step(1'b1, IDLE, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, '0);
    step(1'b1, r3, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, '0);
    for (int j = 0; j < 4; j++)
      step(1'b1, r7, 1'b1, 1'b1, 4'd7, 1'b0, j >= 1, B);

    // freeze mid-verify, then resume at the new offset
    for (int i = 0; i < 2; i++) step(1'b0, r3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 3; i++)
      step(1'b1, r3, 1'b1, 1'b0, (i >= 2) ? 4'd3 : 4'd0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++)
      step(1'b1, r7, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 5; i++)
      step(1'b1, r7, 1'b1, i >= 4, 4'd7, 1'b0, i >= 2, B);

    // disabled while locked: misaligned commas are ignored
    for (int i = 0; i < 10; i++)
      step(1'b1, r3, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, '0);

    // one-cycle reset while locked
    step(1'b0, r7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 6; i++)
      step(1'b1, r7, 1'b1, i >= 5, (i >= 2) ? 4'd7 : 4'd0, 1'b0, 1'b1,
           (i == 1) ? '0 : ((i == 2) ? r7 : B));

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    cmp("scoreboard_drain", 40'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jesd204_soft_pcs_rx_comma_align.md
Name: jesd204_soft_pcs_rx_comma_align

Overview:
Word aligner upstream of the soft-PCS 8b10b decoder lanes. It takes raw, unaligned DATA_PATH_WIDTH×10-bit beats from the transceiver, with bit 0 first on the wire (bit 0 = 'a'). It searches for the K28.5 comma, locks a 0..9 bit offset after repeated confirmation, and emits symbol-aligned beats. Symbol j of out_data occupies bits [10j+9:10j] and feeds decoder lane j.

Parameters:
DATA_PATH_WIDTH, 4, symbols per beat; W = 10*DATA_PATH_WIDTH.
LOCK_COUNT, 4, consecutive comma beats at the same offset required to lock (2..15).
UNLOCK_COUNT, 8, misaligned-comma beats in LOCKED before lock is dropped (1..15).

Ports:
clk  input  1  core clock, one beat per cycle, no valid qualifier
resetn  input  1  asynchronous active-low reset
patternalign_en  input  1  1 = search/track allowed; 0 = freeze state and offset
in_data  input  W  raw transceiver beat
out_data  output  W  aligned beat
out_locked  output  1  alignment locked
out_offset  output  4  current bit offset, 0..9
out_lock_lost  output  1  one-cycle pulse when LOCKED exits to SEARCH

Behaviour:
- Reset (resetn=0, async assert, sync release): state=SEARCH, offset=0, counters=0, prev=0, out_data=0, out_locked=0, out_offset=0, out_lock_lost=0.
- prev <= in_data each cycle. window = {in_data, prev} (2W bits, prev in low half).
- Comma patterns in window[p+6:p] with bit p = 'a': 7'b1111100 (RD−) or 7'b0000011 (RD+).
- hit[k], k=0..9 = comma at p=10j+k for any lane j in 0..DATA_PATH_WIDTH-1. All p stay inside the window.
- first_k = lowest k with hit[k]=1. any_hit = |hit. cur_hit = hit[offset].
- out_data <= window[offset+W-1:offset], registered.
  - Latency: with offset=0, out_data at cycle n+1 = in_data of cycle n-1 (2 cycles).
  - An offset change applies from the cycle after it is registered. No output blanking.
- FSM, evaluated only when patternalign_en=1; otherwise state, offset and counters hold:
  - SEARCH: if any_hit, then offset<=first_k, cnt<=1, go VERIFY. If LOCK_COUNT==1, go directly to LOCKED.
  - VERIFY:
    - cur_hit: cnt+1. When cnt+1==LOCK_COUNT, go LOCKED, out_locked<=1, miss<=0.
    - Not cur_hit but any_hit: offset<=first_k, cnt<=1, stay VERIFY.
    - No hit: hold.
  - LOCKED:
    - cur_hit: miss<=0.
    - Not cur_hit but any_hit: miss+1. When miss+1==UNLOCK_COUNT, go SEARCH, out_locked<=0, out_lock_lost<=1 for one cycle, cnt<=0. Offset is retained until the next SEARCH hit.
    - No hit (data phase): no change.
- Multiple hits at different k in one beat: cur_hit takes precedence; otherwise first_k is used.
- Counters saturate at 4 bits, which cannot be exceeded under the parameter bounds.
- out_offset mirrors the offset register.
- patternalign_en 1→0 while LOCKED keeps out_locked=1.
- Reset mid-VERIFY or mid-LOCKED returns everything to the reset values immediately.

Decomposition:
- Shared package jesd204_soft_pcs_pkg:
  - comma constants COMMA_NEG=7'b1111100, COMMA_POS=7'b0000011;
  - state encodings SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2;
  - symbol width constant 10.
- Sub-module jesd204_comma_detect: combinational, parameter DATA_PATH_WIDTH; takes window, outputs hit[9:0] and first_k[3:0].
- FSM, counters and output mux live in the top module.

Test Plan:
- Offset 0: each beat = {D21.5×3, K28.5 RD− 10'b0101111100 in lane 0}, patternalign_en=1 -> out_locked rises on the 4th comma beat; out_offset=0; out_data = in_data delayed 2 cycles.
- Same stream shifted by 3 bits -> out_offset=3, lock after 4 beats, out_data lane 0 = 10'b0101111100 every beat.
- Locked at 3, then stream re-shifted to 7 -> out_lock_lost pulses on the 8th beat; out_locked=0; relock at offset 7 within 5 beats; out_offset=7.
- Locked, then 100 beats with no commas, then 1 misaligned comma beat, then 1 aligned comma beat -> out_locked stays 1, no lock_lost pulse.
- Mid-VERIFY (cnt=2), patternalign_en=0 with stream shifted -> offset and state frozen; re-enable -> search restarts at the new offset.
- Assert resetn=0 for 1 cycle while LOCKED -> all outputs 0 asynchronously; relock after LOCK_COUNT beats.
